polar_encoder: RTL



---
 rtl/polar_encoder_if.sv | 40 ++++
 rtl/polar_encoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/polar_encoder_if.sv
// -----------------------------------------------------------------------------
// polar_encoder_if
//   Frame-request, info-bit and codeword handshake bundle for polar_encoder.
//   The source (bench, loopback driver) uses the master modport and the
//   encoder uses the slave modport.
//
//   Signals:
//     start        frame request, one cycle, honoured only while encoder idle
//     frozen_mask  N-bit frozen-position mask (1 = frozen), latched on start
//     info_valid   info_bit carries a valid information bit
//     info_bit     next information bit, ascending position order
//     info_ready   encoder consumes info_bit this cycle
//     cw_valid     codeword valid
//     cw           N-bit codeword, bit i = x_i
//     cw_ready     sink accepts cw
//     busy         encoder is not idle
// -----------------------------------------------------------------------------
interface polar_encoder_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] frozen_mask;
  logic         info_valid;
  logic         info_bit;
  logic         info_ready;
  logic         cw_valid;
  logic [N-1:0] cw;
  logic         cw_ready;
  logic         busy;

  modport master (
    output start, frozen_mask, info_valid, info_bit, cw_ready,
    input  info_ready, cw_valid, cw, busy
  );

  modport slave (
    input  start, frozen_mask, info_valid, info_bit, cw_ready,
    output info_ready, cw_valid, cw, busy
  );
endinterface

// File: rtl/polar_encoder.sv
// -----------------------------------------------------------------------------
// polar_encoder
//   Sequential polar encoder. Builds u by placing serial information bits at
//   the unfrozen positions of a per-frame frozen mask (frozen positions = 0),
//   then applies x = u * F^(kron n) in place, one butterfly stage per cycle,
//   and presents x under a valid/ready handshake.
//
//   Parameters:
//     N      code length, power of two, 8..512
//     LOG_N  log2(N)
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    polar_encoder_if.slave (start/mask, info stream, codeword, busy)
//
//   Build option:
//     BIT_REVERSE_EN  when defined, cw[i] = x[bitrev(i)] (output wiring only,
//                     no latency change); otherwise cw[i] = x[i].
// -----------------------------------------------------------------------------
module polar_encoder #(
  parameter int N     = 8,
  parameter int LOG_N = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  polar_encoder_if.slave  bus
);

  localparam int SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    XFORM = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       mask_q;
  logic [N-1:0]       u_q;        // u during LOAD, x in progress during XFORM
  logic [LOG_N-1:0]   idx_q;
  logic [SW-1:0]      stage_q;
  logic [N-1:0]       cw_q;
  logic               cw_valid_q;

  logic               info_ready;
  logic               load_adv;
  logic               load_last;
  logic               xform_last;
  logic [N-1:0]       xform_next;

  // Output ordering of the codeword; a pure wiring permutation.
  function automatic logic [N-1:0] out_perm(input logic [N-1:0] x);
    logic [N-1:0] y;
`ifdef BIT_REVERSE_EN
    int r;
    for (int i = 0; i < N; i++) begin
      r = 0;
      for (int b = 0; b < LOG_N; b++)
        if (((i >> b) & 1) == 1) r |= 1 << (LOG_N - 1 - b);
      y[i] = x[r];
    end
`else
    y = x;
`endif
    return y;
  endfunction

  // One butterfly stage: for every j with bit s clear, x[j] ^= x[j + 2^s].
  always_comb begin
    xform_next = u_q;
    for (int k = 0; k < LOG_N; k++) begin
      if (stage_q == SW'(k)) begin
        for (int j = 0; j < N; j++) begin
          if (((j >> k) & 1) == 0) xform_next[j] = u_q[j] ^ u_q[j + (1 << k)];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps this block free of latches
  // on any path that does not assign state_d.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start)               state_d = LOAD;
      LOAD:    if (load_adv && load_last)   state_d = XFORM;
      XFORM:   if (xform_last)              state_d = DONE;
      DONE:    if (bus.cw_ready)            state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs / control (registered state only, no path from info_valid
  // into info_ready)
  // ---------------------------------------------------------------------------
  always_comb begin
    info_ready = 1'b0;
    load_adv   = 1'b0;
    if (state_q == LOAD) begin
      info_ready = !mask_q[idx_q];
      load_adv   = mask_q[idx_q] || bus.info_valid;
    end
    load_last  = (idx_q == LOG_N'(N - 1));
    xform_last = (stage_q == SW'(LOG_N - 1));
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // NOTE: every datapath register, including the u/x vector and the held
  // codeword, is reset so an aborted frame leaves nothing behind on cw.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q     <= '0;
      u_q        <= '0;
      idx_q      <= '0;
      stage_q    <= '0;
      cw_q       <= '0;
      cw_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            mask_q  <= bus.frozen_mask;
            u_q     <= '0;
            idx_q   <= '0;
            stage_q <= '0;
          end
        end
        LOAD: begin
          if (load_adv) begin
            u_q[idx_q] <= bus.info_bit & ~mask_q[idx_q];
            idx_q      <= idx_q + 1'b1;
          end
        end
        XFORM: begin
          u_q     <= xform_next;
          stage_q <= stage_q + 1'b1;
          // cw is loaded only with a finished codeword and then held.
          if (xform_last) begin
            cw_q       <= out_perm(xform_next);
            cw_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.cw_ready) cw_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.info_ready = info_ready;
  assign bus.cw_valid   = cw_valid_q;
  assign bus.cw         = cw_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
